wave_generator: RTL

Parametrised multi-mode waveform generator that produces a duty-cycle code for the downstream PWM stage. It replaces the fixed 6-bit triangle lookup with an arithmetic phase accumulator of configurable width. It adds selectable triangle, sawtooth-up, sawtooth-down and square shapes, a synchronous phase clear, and a period-start strobe for scope triggering and channel alignment. It sits between the switch/scale inputs and the PWM comparator.

---
 rtl/wave_gen_pkg.sv | 13 +
 rtl/wave_tick_prescaler.sv | 47 ++++
 rtl/wave_generator.sv | 80 ++++++++
 3 files changed

// File: rtl/wave_gen_pkg.sv
// rtl/wave_gen_pkg.sv - shared waveform mode encodings for the wave generator
package wave_gen_pkg;

  // Width of the waveform select field
  localparam int WAVE_MODE_W = 2;

  // Waveform select encodings
  localparam logic [WAVE_MODE_W-1:0] WAVE_TRI    = 2'd0;
  localparam logic [WAVE_MODE_W-1:0] WAVE_SAW_UP = 2'd1;
  localparam logic [WAVE_MODE_W-1:0] WAVE_SAW_DN = 2'd2;
  localparam logic [WAVE_MODE_W-1:0] WAVE_SQUARE = 2'd3;

endpackage

// File: rtl/wave_tick_prescaler.sv
// rtl/wave_tick_prescaler.sv - free-running prescaler plus scale step counter
module wave_tick_prescaler
  import wave_gen_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int SCALE_W    = 6
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               clr,
  input  logic [SCALE_W-1:0] scale,
  output logic               step_en
);

  logic [PRESCALE_W-1:0] pre;
  logic [SCALE_W-1:0]    step;
  logic [SCALE_W-1:0]    step_limit;
  logic                  tick;
  logic                  step_done;

  // Tick decode and step completion; a zero scale behaves like one, and the
  // >= compare lets a shrinking scale finish the step on the next tick
  always_comb begin
    tick       = &pre;
    step_limit = (scale == '0) ? '0 : (scale - SCALE_W'(1));
    step_done  = (step >= step_limit);
    step_en    = tick & step_done & ~clr;
  end

  // Prescaler and step counter; clear wins over any coincident tick
  always_ff @(posedge sysclk) begin
    if (rst || clr) begin
      pre  <= '0;
      step <= '0;
    end else begin
      pre <= pre + PRESCALE_W'(1);
      if (tick) begin
        if (step_done) begin
          step <= '0;
        end else begin
          step <= step + SCALE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/wave_generator.sv
// rtl/wave_generator.sv - phase accumulator waveform generator feeding the PWM stage
module wave_generator
  import wave_gen_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int PRESCALE_W = 6,
  parameter int SCALE_W    = 6
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [WAVE_MODE_W-1:0] mode,
  input  logic [SCALE_W-1:0]     scale,
  input  logic                   phase_clr,
  output logic [WIDTH-1:0]       duty_out,
  output logic                   period_start
);

  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] shape;
  logic [WIDTH-2:0] phase_low;
  logic             phase_msb;
  logic             step_en;
  logic             wrap_pend;

  wave_tick_prescaler #(
    .PRESCALE_W (PRESCALE_W),
    .SCALE_W    (SCALE_W)
  ) u_prescaler (
    .sysclk  (sysclk),
    .rst     (rst),
    .clr     (phase_clr),
    .scale   (scale),
    .step_en (step_en)
  );

  // Shape mux: derive the selected waveform from the current phase
  always_comb begin
    phase_low = phase[WIDTH-2:0];
    phase_msb = phase[WIDTH-1];
    shape     = phase;
    case (mode)
      WAVE_TRI:    shape = phase_msb ? {~phase_low, 1'b0} : {phase_low, 1'b0};
      WAVE_SAW_UP: shape = phase;
      WAVE_SAW_DN: shape = ~phase;
      WAVE_SQUARE: shape = {WIDTH{~phase_msb}};
      default:     shape = phase;
    endcase
  end

  // Phase accumulator, wrapping naturally at 2^WIDTH
  always_ff @(posedge sysclk) begin
    if (rst || phase_clr) begin
      phase <= '0;
    end else if (step_en) begin
      phase <= phase + WIDTH'(1);
    end
  end

  // Wrap strobe, delayed one stage so it lines up with duty_out showing phase 0
  always_ff @(posedge sysclk) begin
    if (rst) begin
      wrap_pend    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      wrap_pend    <= step_en & ~phase_clr & (&phase);
      period_start <= wrap_pend;
    end
  end

  // Output register with enable gating; counters run on regardless of enable
  always_ff @(posedge sysclk) begin
    if (rst) begin
      duty_out <= '0;
    end else begin
      duty_out <= enable ? shape : '0;
    end
  end

endmodule
